// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, control-bundle bit positions, per-opcode control constants and
// the immediate-format enum shared by the decode stage.
// Optional feature macro used elsewhere in this slice: DECODE_WB_BYPASS_EN.
package decode_pkg;

  // RV32 base opcodes
  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  // ex bundle: {alu_src_imm, alu_op[1:0], branch, jump, jalr, a_sel_pc}
  localparam int unsigned ExAluSrcImm = 6;
  localparam int unsigned ExAluOpHi   = 5;
  localparam int unsigned ExAluOpLo   = 4;
  localparam int unsigned ExBranch    = 3;
  localparam int unsigned ExJump      = 2;
  localparam int unsigned ExJalr      = 1;
  localparam int unsigned ExASelPc    = 0;
  // mem bundle: {mem_read, mem_write}
  localparam int unsigned MemRead     = 1;
  localparam int unsigned MemWrite    = 0;
  // wb bundle: {reg_write, mem_to_reg}
  localparam int unsigned WbRegWrite  = 1;
  localparam int unsigned WbMemToReg  = 0;

  typedef struct packed {
    logic [6:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
  } ctrl_t;

  localparam ctrl_t CtrlNone   = '{ex: 7'b0000000, mem: 2'b00, wb: 2'b00};
  localparam ctrl_t CtrlR      = '{ex: 7'b0100000, mem: 2'b00, wb: 2'b10};
  localparam ctrl_t CtrlImm    = '{ex: 7'b1100000, mem: 2'b00, wb: 2'b10};
  localparam ctrl_t CtrlLoad   = '{ex: 7'b1000000, mem: 2'b10, wb: 2'b11};
  localparam ctrl_t CtrlStore  = '{ex: 7'b1000000, mem: 2'b01, wb: 2'b00};
  localparam ctrl_t CtrlBranch = '{ex: 7'b0011000, mem: 2'b00, wb: 2'b00};
  localparam ctrl_t CtrlJal    = '{ex: 7'b1000101, mem: 2'b00, wb: 2'b10};
  localparam ctrl_t CtrlJalr   = '{ex: 7'b1000110, mem: 2'b00, wb: 2'b10};
  localparam ctrl_t CtrlLui    = '{ex: 7'b1110000, mem: 2'b00, wb: 2'b10};
  localparam ctrl_t CtrlAuipc  = '{ex: 7'b1000001, mem: 2'b00, wb: 2'b10};

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_fmt_e;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch handshake, write-back port and ID/EX outputs of the decode stage.
// master = environment side (fetch/execute/write-back), slave = decode_stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_ex_ctrl;
  logic [1:0]      out_mem_ctrl;
  logic [1:0]      out_wb_ctrl;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_illegal;
  logic [15:0]     hazard_stalls;

  modport master (
    output in_valid, in_instr, in_pc, flush, wb_reg_write, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_ex_ctrl, out_mem_ctrl, out_wb_ctrl, out_rs1_data,
           out_rs2_data, out_imm, out_pc, out_rd, out_rs1, out_rs2, out_illegal, hazard_stalls
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, wb_reg_write, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_ex_ctrl, out_mem_ctrl, out_wb_ctrl, out_rs1_data,
           out_rs2_data, out_imm, out_pc, out_rd, out_rs1, out_rs2, out_illegal, hazard_stalls
  );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: NREGS x XLEN register file, two combinational read ports, one synchronous
// write port, synchronous reset. x0 and indices >= NREGS read as zero and ignore writes.
// DECODE_WB_BYPASS_EN: a read of the register being written this cycle returns the write data.
module id_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            we_i,
  input  logic [4:0]      wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (wr_addr_i != 5'd0) && (32'(wr_addr_i) < NREGS);

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] data;
    data = '0;
    if (addr != 5'd0 && 32'(addr) < NREGS) begin
      data = mem_q[addr[AW-1:0]];
    end
`ifdef DECODE_WB_BYPASS_EN
    if (wr_en && wr_addr_i == addr) begin
      data = wr_data_i;
    end
`endif
    return data;
  endfunction

  // Combinational read ports
  always_comb begin
    rs1_data_o = read_port(rs1_addr_i);
    rs2_data_o = read_port(rs2_addr_i);
  end

  // Synchronous write port and reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr_i[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32 decode with integrated ID/EX register, load-use / write-back hazard
// stalls, flush and a saturating stall counter.
// DECODE_WB_BYPASS_EN: when defined, same-cycle write-back is forwarded by the register file
// instead of stalling decode for one cycle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus_io
);

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            illegal;
  } idex_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  ctrl_t           ctrl;
  imm_fmt_e        fmt;
  logic            illegal, use_rs1, use_rs2;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            load_use, wb_hazard, hazard, in_ready, accept;

  idex_t       idex_d, idex_q;
  logic        valid_d, valid_q;
  logic [15:0] stalls_d, stalls_q;

  assign instr  = bus_io.in_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Control bundle, immediate format and source usage per opcode
  always_comb begin
    ctrl    = CtrlNone;
    fmt     = ImmNone;
    illegal = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    unique case (opcode)
      OpcR:      begin ctrl = CtrlR;      use_rs2 = 1'b1;                end
      OpcImm:    begin ctrl = CtrlImm;    fmt = ImmI;                    end
      OpcLoad:   begin ctrl = CtrlLoad;   fmt = ImmI;                    end
      OpcStore:  begin ctrl = CtrlStore;  fmt = ImmS; use_rs2 = 1'b1;    end
      OpcBranch: begin ctrl = CtrlBranch; fmt = ImmB; use_rs2 = 1'b1;    end
      OpcJal:    begin ctrl = CtrlJal;    fmt = ImmJ; use_rs1 = 1'b0;    end
      OpcJalr:   begin ctrl = CtrlJalr;   fmt = ImmI;                    end
      OpcLui:    begin ctrl = CtrlLui;    fmt = ImmU; use_rs1 = 1'b0;    end
      OpcAuipc:  begin ctrl = CtrlAuipc;  fmt = ImmU; use_rs1 = 1'b0;    end
      default:   illegal = 1'b1;
    endcase
  end

  // Immediate generation, sign-extended to XLEN
  always_comb begin
    imm32 = '0;
    unique case (fmt)
      ImmI:    imm32 = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm32 = {instr[31:12], 12'b0};
      ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_ext = XLEN'($signed(imm32));
  end

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .we_i       (bus_io.wb_reg_write),
    .wr_addr_i  (bus_io.wb_rd),
    .wr_data_i  (bus_io.wb_data)
  );

  // Hazard detection and the input handshake
  always_comb begin
    load_use = valid_q && idex_q.ctrl.mem[MemRead] && (idex_q.rd != 5'd0) &&
               ((use_rs1 && rs1 == idex_q.rd) || (use_rs2 && rs2 == idex_q.rd));
`ifdef DECODE_WB_BYPASS_EN
    wb_hazard = 1'b0;
`else
    // Without forwarding, wait one cycle so the read sees the written file
    wb_hazard = bus_io.wb_reg_write && (bus_io.wb_rd != 5'd0) &&
                ((use_rs1 && rs1 == bus_io.wb_rd) || (use_rs2 && rs2 == bus_io.wb_rd));
`endif
    hazard   = load_use || wb_hazard;
    in_ready = (!valid_q || bus_io.out_ready) && !hazard && !bus_io.flush;
    accept   = bus_io.in_valid && in_ready;
  end

  // ID/EX next state and stall counter; flush outranks accept and drain
  always_comb begin
    valid_d  = valid_q;
    idex_d   = idex_q;
    stalls_d = stalls_q;
    if (bus_io.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d         = 1'b1;
      idex_d.ctrl     = ctrl;
      idex_d.rs1_data = rs1_data;
      idex_d.rs2_data = rs2_data;
      idex_d.imm      = imm_ext;
      idex_d.pc       = bus_io.in_pc;
      idex_d.rd       = rd;
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.illegal  = illegal;
    end else if (bus_io.out_ready) begin
      valid_d = 1'b0;
    end
    if (bus_io.in_valid && hazard && !bus_io.flush && stalls_q != 16'hFFFF) begin
      stalls_d = stalls_q + 16'd1;
    end
  end

  // ID/EX register and stall counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      idex_q   <= '0;
      stalls_q <= '0;
    end else begin
      valid_q  <= valid_d;
      idex_q   <= idex_d;
      stalls_q <= stalls_d;
    end
  end

  assign bus_io.in_ready      = in_ready;
  assign bus_io.out_valid     = valid_q;
  assign bus_io.out_ex_ctrl   = idex_q.ctrl.ex;
  assign bus_io.out_mem_ctrl  = idex_q.ctrl.mem;
  assign bus_io.out_wb_ctrl   = idex_q.ctrl.wb;
  assign bus_io.out_rs1_data  = idex_q.rs1_data;
  assign bus_io.out_rs2_data  = idex_q.rs2_data;
  assign bus_io.out_imm       = idex_q.imm;
  assign bus_io.out_pc        = idex_q.pc;
  assign bus_io.out_rd        = idex_q.rd;
  assign bus_io.out_rs1       = idex_q.rs1;
  assign bus_io.out_rs2       = idex_q.rs2;
  assign bus_io.out_illegal   = idex_q.illegal;
  assign bus_io.hazard_stalls = stalls_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, hand sequences for hazards/hold/flush/reset, and
// randomized traffic against a behavioural model of decode_stage.
// Honours DECODE_WB_BYPASS_EN when the bundle is built with it.
module tb_decode_stage;

  localparam int XLEN = 32;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN)) bus ();

  decode_stage #(
    .XLEN  (XLEN),
    .NREGS (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  typedef struct packed {
    logic        valid;
    logic [6:0]  ex;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } ent_t;

  typedef struct packed {
    logic [6:0]  ex;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic [31:0] imm;
    logic        illegal;
    logic        u1;
    logic        u2;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  ex;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic [31:0] imm;
    logic        illegal;
  } vec_t;

  int checks = 0;
  int errors = 0;

  ent_t        ment;
  logic [31:0] mregs [32];
  int          mstall;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic ent_t dut_ent();
    ent_t e;
    e.valid   = bus.out_valid;
    e.ex      = bus.out_ex_ctrl;
    e.mem     = bus.out_mem_ctrl;
    e.wb      = bus.out_wb_ctrl;
    e.rs1d    = bus.out_rs1_data;
    e.rs2d    = bus.out_rs2_data;
    e.imm     = bus.out_imm;
    e.pc      = bus.out_pc;
    e.rd      = bus.out_rd;
    e.rs1     = bus.out_rs1;
    e.rs2     = bus.out_rs2;
    e.illegal = bus.out_illegal;
    return e;
  endfunction

  // Reference decode: immediates assembled arithmetically from the RV32 formats
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic signed [31:0] s;
    logic [31:0] sh20, sh19, sh11;
    s    = w;
    sh20 = s >>> 20;
    sh19 = s >>> 19;
    sh11 = s >>> 11;
    d    = '0;
    d.u1 = 1'b1;
    case (w[6:0])
      7'h33: begin d.ex = 7'b0100000; d.wb = 2'b10; d.u2 = 1'b1; end
      7'h13: begin d.ex = 7'b1100000; d.wb = 2'b10; d.imm = sh20; end
      7'h03: begin d.ex = 7'b1000000; d.mem = 2'b10; d.wb = 2'b11; d.imm = sh20; end
      7'h23: begin
        d.ex = 7'b1000000; d.mem = 2'b01; d.u2 = 1'b1;
        d.imm = (sh20 & ~32'h1F) | ((w >> 7) & 32'h1F);
      end
      7'h63: begin
        d.ex = 7'b0011000; d.u2 = 1'b1;
        d.imm = (sh19 & 32'hFFFFF000) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7E0) |
                ((w >> 7) & 32'h1E);
      end
      7'h6F: begin
        d.ex = 7'b1000101; d.wb = 2'b10; d.u1 = 1'b0;
        d.imm = (sh11 & 32'hFFF00000) | (w & 32'h000FF000) | ((w >> 9) & 32'h800) |
                ((w >> 20) & 32'h7FE);
      end
      7'h67: begin d.ex = 7'b1000110; d.wb = 2'b10; d.imm = sh20; end
      7'h37: begin d.ex = 7'b1110000; d.wb = 2'b10; d.u1 = 1'b0; d.imm = w & 32'hFFFFF000; end
      7'h17: begin d.ex = 7'b1000001; d.wb = 2'b10; d.u1 = 1'b0; d.imm = w & 32'hFFFFF000; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rdval(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wrd, input logic [31:0] wdat);
    if (Bypass && we && wrd != 5'd0 && wrd == idx) return wdat;
    return mregs[idx];
  endfunction

  // Drive one cycle, check in_ready, advance the model, check registered outputs
  task automatic step(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wdat, input string tag);
    dec_t d;
    logic [4:0] r1, r2;
    logic lu, wbm, haz, rdy;
    bus.in_valid     = iv;
    bus.in_instr     = instr;
    bus.in_pc        = pc;
    bus.out_ready    = ordy;
    bus.flush        = fl;
    bus.wb_reg_write = we;
    bus.wb_rd        = wrd;
    bus.wb_data      = wdat;
    #1;
    d   = ref_decode(instr);
    r1  = instr[19:15];
    r2  = instr[24:20];
    lu  = ment.valid && ment.mem[1] && ment.rd != 5'd0 &&
          ((d.u1 && r1 == ment.rd) || (d.u2 && r2 == ment.rd));
    wbm = we && wrd != 5'd0 && ((d.u1 && r1 == wrd) || (d.u2 && r2 == wrd));
    haz = lu || (wbm && !Bypass);
    rdy = (!ment.valid || ordy) && !haz && !fl;
    check({tag, "_ready"}, 256'(bus.in_ready), 256'(rdy));
    if (fl) begin
      ment.valid = 1'b0;
    end else if (iv && rdy) begin
      ment.valid   = 1'b1;
      ment.ex      = d.ex;
      ment.mem     = d.mem;
      ment.wb      = d.wb;
      ment.rs1d    = rdval(r1, we, wrd, wdat);
      ment.rs2d    = rdval(r2, we, wrd, wdat);
      ment.imm     = d.imm;
      ment.pc      = pc;
      ment.rd      = instr[11:7];
      ment.rs1     = r1;
      ment.rs2     = r2;
      ment.illegal = d.illegal;
    end else if (ordy) begin
      ment.valid = 1'b0;
    end
    if (iv && haz && !fl && mstall < 65535) mstall++;
    if (we && wrd != 5'd0) mregs[wrd] = wdat;
    @(posedge clk);
    #1;
    check({tag, "_out"}, 256'(dut_ent()), 256'(ment));
    check({tag, "_stalls"}, 256'(bus.hazard_stalls), 256'(mstall));
  endtask

  task automatic idle(input string tag);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, tag);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_instr     = '0;
    bus.in_pc        = '0;
    bus.out_ready    = 1'b0;
    bus.flush        = 1'b0;
    bus.wb_reg_write = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    ment   = '0;
    mstall = 0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  vec_t vecs [12];
  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                           7'h7F};

  initial begin
    vecs[0]  = '{32'h00500093, 7'b1100000, 2'b00, 2'b10, 32'h00000005, 1'b0};  // addi x1,x0,5
    vecs[1]  = '{32'h00318233, 7'b0100000, 2'b00, 2'b10, 32'h00000000, 1'b0};  // add x4,x3,x3
    vecs[2]  = '{32'h0000A283, 7'b1000000, 2'b10, 2'b11, 32'h00000000, 1'b0};  // lw x5,0(x1)
    vecs[3]  = '{32'hFE20AE23, 7'b1000000, 2'b01, 2'b00, 32'hFFFFFFFC, 1'b0};  // sw x2,-4(x1)
    vecs[4]  = '{32'hFE208CE3, 7'b0011000, 2'b00, 2'b00, 32'hFFFFFFF8, 1'b0};  // beq -8
    vecs[5]  = '{32'h001000EF, 7'b1000101, 2'b00, 2'b10, 32'h00000800, 1'b0};  // jal +2048
    vecs[6]  = '{32'h00C08067, 7'b1000110, 2'b00, 2'b10, 32'h0000000C, 1'b0};  // jalr 12(x1)
    vecs[7]  = '{32'hABCDE137, 7'b1110000, 2'b00, 2'b10, 32'hABCDE000, 1'b0};  // lui
    vecs[8]  = '{32'h80000197, 7'b1000001, 2'b00, 2'b10, 32'h80000000, 1'b0};  // auipc
    vecs[9]  = '{32'h0000007F, 7'b0000000, 2'b00, 2'b00, 32'h00000000, 1'b1};  // illegal
    vecs[10] = '{32'hFFF08093, 7'b1100000, 2'b00, 2'b10, 32'hFFFFFFFF, 1'b0};  // addi -1
    vecs[11] = '{32'hFFDFF06F, 7'b1000101, 2'b00, 2'b10, 32'hFFFFFFFC, 1'b0};  // jal -4

    // Reset state
    do_reset();
    check("reset_out", 256'(dut_ent()), 256'(0));
    check("reset_stalls", 256'(bus.hazard_stalls), 256'(0));
    check("reset_ready", 256'(bus.in_ready), 256'(1));

    // Table vectors, each followed by an idle cycle
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "vec");
      check($sformatf("vec%0d", i),
            256'({bus.out_valid, bus.out_ex_ctrl, bus.out_mem_ctrl, bus.out_wb_ctrl,
                  bus.out_imm, bus.out_illegal, bus.out_pc}),
            256'({1'b1, vecs[i].ex, vecs[i].mem, vecs[i].wb, vecs[i].imm, vecs[i].illegal,
                  32'h1000 + 32'(i) * 4}));
      idle("vec_idle");
    end

    // Write-back then read both operands
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, "wb3");
    step(1'b1, 32'h00318233, 32'h40, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "add4");
    check("add4_ops", 256'({bus.out_rs1_data, bus.out_rs2_data}),
          256'({32'hDEADBEEF, 32'hDEADBEEF}));

    // Writes to x0 are dropped
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, "wb0");
    step(1'b1, 32'h000004B3, 32'h44, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "add9");
    check("x0_read", 256'(bus.out_rs1_data), 256'(0));

    // Load-use: one bubble then the dependent add
    do_reset();
    step(1'b1, 32'h0000A283, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "lw5");
    step(1'b1, 32'h00228333, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "lu_stall");
    check("lu_bubble", 256'(bus.out_valid), 256'(0));
    step(1'b1, 32'h00228333, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "lu_add");
    check("lu_add6", 256'({bus.out_valid, bus.out_rd, bus.out_pc}),
          256'({1'b1, 5'd6, 32'h104}));
    check("lu_count", 256'(bus.hazard_stalls), 256'(1));

    // Same-cycle write-back to a source
    do_reset();
    step(1'b1, 32'h00038433, 32'h200, 1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678, "wbx7");
`ifdef DECODE_WB_BYPASS_EN
    check("byp_op", 256'({bus.out_valid, bus.out_rs1_data, bus.hazard_stalls}),
          256'({1'b1, 32'h12345678, 16'd0}));
`else
    check("nobyp_stall", 256'({bus.out_valid, bus.hazard_stalls}), 256'({1'b0, 16'd1}));
    step(1'b1, 32'h00038433, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "wbx7b");
    check("nobyp_op", 256'({bus.out_valid, bus.out_rs1_data, bus.hazard_stalls}),
          256'({1'b1, 32'h12345678, 16'd1}));
`endif

    // Hold under backpressure, then flush
    do_reset();
    step(1'b1, 32'h00500093, 32'h2000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "addi");
    check("addi_out", 256'({bus.out_valid, bus.out_imm, bus.out_ex_ctrl, bus.out_wb_ctrl}),
          256'({1'b1, 32'd5, 7'b1100000, 2'b10}));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00318233, 32'h2004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, "hold");
      check($sformatf("hold%0d", i), 256'({bus.out_valid, bus.out_imm, bus.out_pc,
            bus.out_rd}), 256'({1'b1, 32'd5, 32'h2000, 5'd1}));
    end
    step(1'b1, 32'h00318233, 32'h2004, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, "flush");
    check("flush_clr", 256'(bus.out_valid), 256'(0));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, "flush_drop");
    check("flush_drop_v", 256'(bus.out_valid), 256'(0));

    // Reset in the middle of a stall discards the held entry
    do_reset();
    step(1'b1, 32'h0000A283, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "ms_lw");
    step(1'b1, 32'h00228333, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, "ms_stall");
    do_reset();
    check("midstall_rst", 256'({dut_ent(), bus.hazard_stalls}), 256'(0));

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] w;
      w        = $urandom;
      w[6:0]   = ops[$urandom_range(0, 9)];
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), w, $urandom, 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) < 2),
           5'($urandom_range(0, 7)), $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RV32 decode stage with an integrated ID/EX pipeline register. It accepts instructions from fetch over a valid/ready handshake and reads a parametrised register file with optional write-back bypass. It detects load-use and write-back hazards, inserts bubbles, and honours flushes. Outputs are registered control bundles, operands, immediate and indices for execute and the forwarding unit.

## Interface
- XLEN, 32: datapath width.
- NREGS, 32: architectural registers (16 for RV32E); x0 hardwired zero.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  squash held and incoming instruction.
- wb_reg_write  in  1  write-back enable.
- wb_rd  in  5  write-back destination.
- wb_data  in  XLEN  write-back value.
- out_valid  out  1  ID/EX entry valid.
- out_ready  in  1  execute consumes the entry.
- out_ex_ctrl  out  7  {alu_src_imm, alu_op[1:0], branch, jump, jalr, a_sel_pc}.
- out_mem_ctrl  out  2  {mem_read, mem_write}.
- out_wb_ctrl  out  2  {reg_write, mem_to_reg}.
- out_rs1_data, out_rs2_data  out  XLEN  operands.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  passed-through PC.
- out_rd, out_rs1, out_rs2  out  5  register indices.
- out_illegal  out  1  unrecognised opcode.
- hazard_stalls  out  16  saturating count of hazard stall cycles.

## Operation
- Control per opcode (ex/mem/wb):
  - R 0110011: 0_10_0000/00/10. I-ALU 0010011: 1_10_0000/00/10. LOAD 0000011: 1_00_0000/10/11. STORE 0100011: 1_00_0000/01/00.
  - BRANCH 1100011: 0_01_1000/00/00. JAL 1101111: 1_00_0101/00/10. JALR 1100111: 1_00_0110/00/10. LUI 0110111: 1_11_0000/00/10. AUIPC 0010111: 1_00_0001/00/10.
  - Any other opcode: all control zero and out_illegal=1.
- Immediates follow RV32 I/S/B/U/J formats, sign-extended to XLEN. R-type immediate is 0.
- Source usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by R, STORE and BRANCH.
  - Unused sources never cause hazards.
- Register indices ≥ NREGS read as 0 and writes to them are ignored. Writes to x0 are ignored.
- Load-use hazard: out_valid && out_mem_ctrl[1] && out_rd≠0 && out_rd equals a used source of in_instr.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept (in_valid && in_ready) loads the ID/EX register. out_valid is set next cycle.
- When the entry leaves (out_ready) and no accept occurs, out_valid clears. This is the bubble.
- A hazard with out_ready set: the load leaves and a bubble follows. The dependent instruction is accepted the next cycle.
- flush: out_valid clears next cycle and the incoming instruction is dropped. flush has priority over everything except reset.
- hazard_stalls increments on each cycle with in_valid && hazard && !flush. It saturates at 0xFFFF.

## Timing
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle absent hazards.
- Register file writes on the rising edge when wb_reg_write is set.
- Outputs hold stable while out_valid && !out_ready.
- Reset:
  - out_valid=0.
  - All out_* data and control are 0 and out_illegal=0.
  - hazard_stalls=0.
  - All registers are 0.
  - in_ready reads 1 the first cycle after reset.
- Reset asserted mid-stall discards the held entry.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A read of a register being written that cycle (wb_reg_write, wb_rd≠0, matching a used source) returns wb_data.
  - No extra stall.
- DECODE_WB_BYPASS_EN undefined:
  - That same match is an additional hazard term.
  - in_ready=0 for that cycle and hazard_stalls counts it.
  - The read occurs the next cycle from the updated file.

## Structure
- Package decode_pkg holds:
  - opcode localparams;
  - the control-bit positions of ex/mem/wb bundles;
  - the per-opcode control constants;
  - the immediate-format enum.
- Sub-module id_regfile: NREGS×XLEN, two combinational read ports, one synchronous write port, synchronous reset, bypass under the macro.
- Control decode, immediate generation, hazard logic and the ID/EX register live in decode_stage.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093): one cycle later out_valid=1, out_imm=5, out_ex_ctrl=7'b1100000, out_wb_ctrl=2'b10.
- Write x3=0xDEADBEEF via WB, then ADD x4,x3,x3: out_rs1_data=out_rs2_data=0xDEADBEEF.
- LW x5,0(x1), then ADD x6,x5,x2 with out_ready=1: one bubble cycle (out_valid=0) before ADD appears; hazard_stalls=1.
- WB to x7 in the same cycle ADD x8,x7,x0 is presented:
  - with macro, operand = wb_data and there is no stall;
  - without macro, one stall and then the correct value.
- out_ready=0 for 3 cycles with in_valid=1: outputs hold and in_ready=0. Assert flush: next cycle out_valid=0 and the new instruction is dropped.
- Opcode 1111111: out_illegal=1, all control 0. Writes to x0 then read: 0.
